// File: rtl/byte_data_memory_pkg.sv
// Shared definitions for the byte-addressable data memory: funct3 encodings,
// default base address, lane count and the size/alignment helpers.
package byte_data_memory_pkg;

  localparam logic [2:0]  F3_B  = 3'b000;
  localparam logic [2:0]  F3_H  = 3'b001;
  localparam logic [2:0]  F3_W  = 3'b010;
  localparam logic [2:0]  F3_BU = 3'b100;
  localparam logic [2:0]  F3_HU = 3'b101;

  localparam logic [31:0] DEFAULT_BASE = 32'h1001_0000;
  localparam int          LANES        = 4;

  // Unsigned sizes exist only for loads; stores with 100/101 are faults.
  function automatic logic size_legal(input logic [2:0] f3,
                                      input logic [1:0] lane,
                                      input logic       is_store);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~lane[0];
      F3_W:    ok = (lane == 2'd0);
      F3_BU:   ok = ~is_store;
      F3_HU:   ok = ~is_store & ~lane[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [LANES-1:0] byte_enables(input logic [2:0] f3,
                                                    input logic [1:0] lane);
    logic [LANES-1:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = 4'b0011 << lane;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/byte_data_memory_dmem_load_align.sv
// Load alignment: selects the addressed byte/halfword from a word and
// applies sign or zero extension according to funct3.
module dmem_load_align
  import byte_data_memory_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_BU:   data = {24'd0, byte_sel};
      F3_HU:   data = {16'd0, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/byte_data_memory.sv
// Byte-addressable RV32 data memory for the MEM stage: per-byte stores,
// one-cycle registered loads with extension, and registered fault pulses.
module byte_data_memory
  import byte_data_memory_pkg::*;
#(
  parameter int                    data_width   = 32,
  parameter int                    memory_depth = 1024,
  parameter int                    addr_width   = 32,
  parameter logic [addr_width-1:0] base_address = DEFAULT_BASE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [addr_width-1:0] address,
  input  logic [data_width-1:0] writedata,
  input  logic                  memwrite,
  input  logic                  memread,
  input  logic [2:0]            funct3,
  output logic [data_width-1:0] readdata,
  output logic                  readvalid,
  output logic                  misaligned,
  output logic                  outofrange
);

  localparam int IDX_W = $clog2(memory_depth);

  logic [addr_width-1:0] offset;
  logic [addr_width-3:0] word_index;
  logic [1:0]            lane;
  logic [IDX_W-1:0]      idx;
  logic                  req;
  logic                  in_range;
  logic                  legal;
  logic                  store_go;
  logic                  load_go;
  logic [LANES-1:0]      be;
  logic [7:0]            wr_byte [LANES];
  logic [data_width-1:0] rd_word;
  logic [data_width-1:0] load_data;

  logic [7:0] mem [memory_depth][LANES];

  logic [data_width-1:0] readdata_d,   readdata_q;
  logic                  readvalid_d,  readvalid_q;
  logic                  misaligned_d, misaligned_q;
  logic                  outofrange_d, outofrange_q;

  always_comb begin
    offset     = address - base_address;
    word_index = offset[addr_width-1:2];
    lane       = offset[1:0];
    idx        = word_index[IDX_W-1:0];
    // Below-base addresses wrap to a huge index, but check explicitly anyway.
    in_range   = (address >= base_address) &&
                 ({2'b00, word_index} < addr_width'(memory_depth));
    req        = memread | memwrite;
    legal      = size_legal(funct3, lane, memwrite);
    store_go   = memwrite & legal & in_range;
    load_go    = memread & ~memwrite & legal & in_range;
    be         = byte_enables(funct3, lane);

    for (int l = 0; l < LANES; l++) begin
      case (funct3[1:0])
        2'b00:   wr_byte[l] = writedata[7:0];
        2'b01:   wr_byte[l] = writedata[8*(l%2) +: 8];
        default: wr_byte[l] = writedata[8*l +: 8];
      endcase
      rd_word[8*l +: 8] = mem[idx][l];
    end
  end

  dmem_load_align u_load_align (
    .word   (rd_word),
    .lane   (lane),
    .funct3 (funct3),
    .data   (load_data)
  );

  always_comb begin
    readdata_d   = load_go ? load_data : readdata_q;
    readvalid_d  = load_go;
    misaligned_d = req & ~legal;
    outofrange_d = req & ~in_range;
  end

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (store_go) begin
      for (int l = 0; l < LANES; l++) begin
        if (be[l]) mem[idx][l] <= wr_byte[l];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      readdata_q   <= '0;
      readvalid_q  <= 1'b0;
      misaligned_q <= 1'b0;
      outofrange_q <= 1'b0;
    end else begin
      readdata_q   <= readdata_d;
      readvalid_q  <= readvalid_d;
      misaligned_q <= misaligned_d;
      outofrange_q <= outofrange_d;
    end
  end

  assign readdata   = readdata_q;
  assign readvalid  = readvalid_q;
  assign misaligned = misaligned_q;
  assign outofrange = outofrange_q;

endmodule

// File: tb/tb_byte_data_memory.sv
// Self-checking bench for byte_data_memory: byte-array reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_byte_data_memory;

  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int          DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address = '0;
  logic [31:0] writedata = '0;
  logic        memwrite = 1'b0;
  logic        memread = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] readdata;
  logic        readvalid;
  logic        misaligned;
  logic        outofrange;

  byte_data_memory dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .writedata  (writedata),
    .memwrite   (memwrite),
    .memread    (memread),
    .funct3     (funct3),
    .readdata   (readdata),
    .readvalid  (readvalid),
    .misaligned (misaligned),
    .outofrange (outofrange)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // Reference model: flat byte array indexed by offset from BASE.
  logic [7:0]  mm [DEPTH*4];
  logic [31:0] exp_data  = '0;
  logic        exp_valid = 1'b0;
  logic        exp_mis   = 1'b0;
  logic        exp_oor   = 1'b0;
  logic [31:0] m_off;
  logic [31:0] m_val;
  int          m_n;
  bit          m_legal;
  bit          m_oor;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_data = '0; exp_valid = 1'b0; exp_mis = 1'b0; exp_oor = 1'b0;
    end else begin
      exp_valid = 1'b0; exp_mis = 1'b0; exp_oor = 1'b0;
      if (memread || memwrite) begin
        m_off = address - BASE;
        m_oor = !(address >= BASE && (m_off >> 2) < DEPTH);
        m_n   = 1 << funct3[1:0];
        if (memwrite) m_legal = (funct3 <= 3'd2);
        else          m_legal = !(funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7);
        if ((m_off % m_n) != 0) m_legal = 1'b0;
        exp_mis = !m_legal;
        exp_oor = m_oor;
        if (m_legal && !m_oor) begin
          if (memwrite) begin
            for (int i = 0; i < m_n; i++) mm[int'(m_off) + i] = 8'(writedata >> (8*i));
          end else begin
            m_val = '0;
            for (int i = 0; i < m_n; i++) m_val = m_val | (32'(mm[int'(m_off) + i]) << (8*i));
            if (!funct3[2] && m_n < 4 && m_val[8*m_n-1]) m_val = m_val | (32'hFFFF_FFFF << (8*m_n));
            exp_data  = m_val;
            exp_valid = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("readvalid",  {31'd0, readvalid},  {31'd0, exp_valid});
      check("misaligned", {31'd0, misaligned}, {31'd0, exp_mis});
      check("outofrange", {31'd0, outofrange}, {31'd0, exp_oor});
      check("readdata",   readdata,            exp_data);
    end
  end

  task automatic req(input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd);
    memread = rd; memwrite = wr; funct3 = f3; address = a; writedata = wd;
    @(posedge clk);
    @(negedge clk);
    memread = 1'b0; memwrite = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    @(negedge clk);
  endtask

  int          sel;
  logic [2:0]  rf3;
  logic [31:0] raddr;

  initial begin
    reset = 1'b0;
    #1;
    check("reset_readdata",   readdata,            32'h0);
    check("reset_readvalid",  {31'd0, readvalid},  32'h0);
    check("reset_misaligned", {31'd0, misaligned}, 32'h0);
    check("reset_outofrange", {31'd0, outofrange}, 32'h0);
    @(negedge clk);
    reset  = 1'b1;
    chk_en = 1'b1;

    for (int w = 0; w < DEPTH; w++) req(1'b0, 1'b1, 3'b010, BASE + 32'(4*w), $urandom);

    req(1'b0, 1'b1, 3'b010, 32'h1001_0004, 32'hDEAD_BEEF);
    req(1'b1, 1'b0, 3'b010, 32'h1001_0004, 32'h0);
    check("lw_deadbeef", readdata, 32'hDEAD_BEEF);
    check("lw_valid", {31'd0, readvalid}, 32'h1);
    idle();
    check("lw_valid_pulse_end", {31'd0, readvalid}, 32'h0);
    check("lw_data_held", readdata, 32'hDEAD_BEEF);

    req(1'b0, 1'b1, 3'b000, 32'h1001_0005, 32'hFFFF_FF7F);
    req(1'b1, 1'b0, 3'b010, 32'h1001_0004, 32'h0);
    check("lw_after_sb", readdata, 32'hDEAD_7FEF);
    req(1'b1, 1'b0, 3'b000, 32'h1001_0007, 32'h0);
    check("lb_sign", readdata, 32'hFFFF_FFDE);
    req(1'b1, 1'b0, 3'b100, 32'h1001_0007, 32'h0);
    check("lbu_zero", readdata, 32'h0000_00DE);
    req(1'b1, 1'b0, 3'b101, 32'h1001_0006, 32'h0);
    check("lhu_zero", readdata, 32'h0000_DEAD);

    req(1'b0, 1'b1, 3'b001, 32'h1001_0003, 32'h0000_1234);
    check("sh_misaligned", {31'd0, misaligned}, 32'h1);
    req(1'b1, 1'b0, 3'b010, 32'h1001_0000, 32'h0);
    req(1'b1, 1'b0, 3'b010, 32'h1001_0002, 32'h0);
    check("lw_misaligned", {31'd0, misaligned}, 32'h1);
    check("lw_misaligned_novalid", {31'd0, readvalid}, 32'h0);

    req(1'b1, 1'b0, 3'b010, 32'h1001_1000, 32'h0);
    check("oor_high", {31'd0, outofrange}, 32'h1);
    check("oor_high_novalid", {31'd0, readvalid}, 32'h0);
    req(1'b1, 1'b0, 3'b010, 32'h1000_FFFC, 32'h0);
    check("oor_low", {31'd0, outofrange}, 32'h1);
    req(1'b0, 1'b1, 3'b010, 32'h1001_0FFC, 32'hCAFE_F00D);
    check("last_word_inrange", {31'd0, outofrange}, 32'h0);
    req(1'b1, 1'b0, 3'b010, 32'h1001_0FFC, 32'h0);
    check("last_word_readback", readdata, 32'hCAFE_F00D);

    req(1'b1, 1'b1, 3'b010, 32'h1001_0008, 32'hA5A5_A5A5);
    check("rdwr_novalid", {31'd0, readvalid}, 32'h0);
    req(1'b1, 1'b0, 3'b010, 32'h1001_0008, 32'h0);
    check("rdwr_store_done", readdata, 32'hA5A5_A5A5);

    memread = 1'b1; funct3 = 3'b010; address = 32'h1001_0008;
    #2 reset = 1'b0;
    #1;
    check("async_reset_data", readdata, 32'h0);
    check("async_reset_valid", {31'd0, readvalid}, 32'h0);
    memread = 1'b0;
    idle();
    reset = 1'b1;
    idle();
    check("no_valid_after_reset", {31'd0, readvalid}, 32'h0);
    req(1'b1, 1'b0, 3'b010, 32'h1001_0008, 32'h0);
    check("retained_after_reset", readdata, 32'hA5A5_A5A5);

    for (int k = 0; k < 800; k++) begin
      sel = int'($urandom_range(0, 9));
      if ($urandom_range(0, 9) < 7) begin
        case ($urandom_range(0, 4))
          0: rf3 = 3'b000;
          1: rf3 = 3'b001;
          2: rf3 = 3'b010;
          3: rf3 = 3'b100;
          default: rf3 = 3'b101;
        endcase
      end else begin
        rf3 = 3'($urandom);
      end
      if (sel == 0)      raddr = BASE - 32'($urandom_range(1, 8));
      else if (sel == 1) raddr = BASE + 32'h1000 + 32'($urandom_range(0, 7));
      else               raddr = BASE + 32'($urandom_range(0, 4095));
      req(1'($urandom), 1'($urandom), rf3, raddr, $urandom);
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/byte_data_memory.md
# byte_data_memory

Byte-addressable RISC-V data memory for the pipelined core, replacing the word-only combinational data memory. It sits in the MEM stage. It decodes load/store size from funct3, applies per-byte write enables, and returns sign- or zero-extended load data one cycle after the request. Misaligned, unsupported-size and out-of-range accesses are flagged and never touch the array.

## Interface
Parameters:
- data_width, 32: word width; fixed at 32 for RV32, split into data_width/8 byte lanes
- memory_depth, 1024: number of words in the array
- addr_width, 32: byte-address width
- base_address, 32'h1001_0000: byte address of word 0

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-low reset
- address  in  addr_width  byte address from the ALU
- writedata  in  data_width  store data, taken from the low bits by size
- memwrite  in  1  store request, one cycle per store
- memread  in  1  load request, one cycle per load
- funct3  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
- readdata  out  data_width  extended load result, registered
- readvalid  out  1  one-cycle pulse when readdata carries a new load result
- misaligned  out  1  one-cycle pulse, registered; size/alignment fault on the request of the previous cycle
- outofrange  out  1  one-cycle pulse, registered; address fault on the request of the previous cycle

## Operation
- Address computation: offset = address − base_address (addr_width, unsigned wrap).
  - word index = offset[addr_width-1:2]; lane = offset[1:0].
  - In range iff address ≥ base_address and word index < memory_depth.
- Size legality:
  - b/bu: any lane.
  - h/hu: lane ∈ {0,2}.
  - w: lane 0.
  - Store funct3 100/101, and any funct3 011/110/111: illegal and reported as misaligned.
- Store (memwrite=1, legal, in range):
  - sb: writes writedata[7:0] to the lane byte.
  - sh: writes writedata[15:0] to lanes lane, lane+1.
  - sw: writes all four lanes.
  - Other bytes of the word are unchanged.
- Load (memread=1, legal, in range):
  - Word read synchronously; the lane is selected and extended.
  - b/h sign-extend; bu/hu zero-extend; w passes the word through.
  - Registered into readdata with readvalid=1.
- Faulted request (either flag):
  - No array write.
  - readvalid=0 and readdata holds its previous value.
  - The flag pulses the next cycle.
  - If both faults apply, both flags pulse.
- memread and memwrite both high: the store is performed, the load is dropped, readvalid=0.
  - Flags are evaluated against the store size rules.
- No request: readvalid=0, flags 0, readdata held.
- Array contents are not reset and are undefined at power-up.

## Timing
- Store: the array is updated at the rising edge where memwrite=1.
- Load: latency 1 cycle. Request at edge N gives readdata/readvalid valid after edge N+1.
  - readdata holds its value until the next successful load.
- Back-to-back: a load in the cycle after a store to the same word returns the new data (read after write).
  - Loads on consecutive cycles each produce one readvalid pulse.
- Flags: registered, asserted during the cycle after the faulting request, for one cycle.
- Reset low (asynchronous):
  - readdata=0, readvalid=0, misaligned=0, outofrange=0 immediately.
  - A load in flight is discarded; no readvalid appears after release.
- Reset release: the first request is accepted at the first rising edge with reset high.
- Throughput: one request per cycle; no stall or ready signal.

## Structure
- Shared package: funct3 load/store encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU), the default base address, and the lane count.
  - The decoder and the forwarding logic import the same package.
- Sub-module dmem_load_align:
  - Combinational lane select plus sign/zero extension from {word, lane, funct3}.
  - Reused by the load-forwarding path.
- Top level holds:
  - range and alignment checks
  - byte-enable generation
  - byte-lane array
  - output registers

## Test plan
- sw 0xDEADBEEF @0x10010004, then lw @0x10010004 -> readdata=0xDEADBEEF, one-cycle readvalid, latency 1.
- sb 0x7F @0x10010005, then:
  - lw @0x10010004 -> 0xDEAD7FEF
  - lb @0x10010007 -> 0xFFFFFFDE
  - lbu @0x10010007 -> 0x000000DE
  - lhu @0x10010006 -> 0x0000DEAD
- sh 0x1234 @0x10010003 -> misaligned pulse, word @0x10010000 unchanged; lw @0x10010002 -> misaligned, no readvalid.
- lw @0x10011000 (word 1024) and lw @0x1000FFFC -> outofrange pulse each, no readvalid.
  - sw @0x10010FFC -> accepted, readback correct.
- memread=memwrite=1, sw 0xA5A5A5A5 @0x10010008 -> write occurs, readvalid=0; next-cycle lw returns 0xA5A5A5A5.
- lw issued, then reset driven low before the next edge -> readdata=0, readvalid never pulses.
  - After release, lw of the previously stored word returns the retained data.
